// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage requester for the multi-cycle divider (start/annul/ready handshake).
module div_issue_ctrl #(
    parameter int DATA_W    = 32,
    parameter int DRAIN_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_req_i,
    input  logic                div_signed_i,
    input  logic [DATA_W-1:0]   op1_i,
    input  logic [DATA_W-1:0]   op2_i,
    input  logic                flush_i,
    input  logic                ex_hold_i,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_ready_i,
    output logic                div_start_o,
    output logic                div_annul_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_op1_o,
    output logic [DATA_W-1:0]   div_op2_o,
    output logic                stallreq_o,
    output logic                whilo_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);
    typedef enum logic [1:0] {IDLE, BUSY, CAPTURE, DRAIN} state_t;
    localparam int CW = $clog2(DRAIN_CYC + 1);

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic start_n, annul_n, signed_n, stall_n, whilo_n;
    logic [DATA_W-1:0] op1_n, op2_n, hi_n, lo_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            div_start_o  <= 1'b0;
            div_annul_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            stallreq_o   <= 1'b0;
            whilo_o      <= 1'b0;
            hi_o         <= '0;
            lo_o         <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            div_start_o  <= start_n;
            div_annul_o  <= annul_n;
            div_signed_o <= signed_n;
            div_op1_o    <= op1_n;
            div_op2_o    <= op2_n;
            stallreq_o   <= stall_n;
            whilo_o      <= whilo_n;
            hi_o         <= hi_n;
            lo_o         <= lo_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        start_n  = div_start_o;
        annul_n  = div_annul_o;
        signed_n = div_signed_o;
        op1_n    = div_op1_o;
        op2_n    = div_op2_o;
        stall_n  = stallreq_o;
        whilo_n  = whilo_o;
        hi_n     = hi_o;
        lo_n     = lo_o;
        case (state)
            IDLE: begin
                start_n = 1'b0;
                annul_n = 1'b0;
                stall_n = 1'b0;
                whilo_n = 1'b0;
                if (div_req_i && !flush_i) begin
                    op1_n    = op1_i;
                    op2_n    = op2_i;
                    signed_n = div_signed_i;
                    start_n  = 1'b1;
                    stall_n  = 1'b1;
                    state_n  = BUSY;
                end
            end
            BUSY: begin
                // a flush outranks a result arriving in the same cycle
                if (flush_i) begin
                    start_n = 1'b0;
                    annul_n = 1'b1;
                    stall_n = 1'b0;
                    cnt_n   = CW'(DRAIN_CYC);
                    state_n = DRAIN;
                end else if (div_ready_i) begin
                    hi_n    = div_result_i[2*DATA_W-1:DATA_W];
                    lo_n    = div_result_i[DATA_W-1:0];
                    whilo_n = 1'b1;
                    start_n = 1'b0;
                    stall_n = 1'b0;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (flush_i || !ex_hold_i) begin
                    whilo_n = 1'b0;
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                start_n = 1'b0;
                annul_n = 1'b1;
                stall_n = div_req_i;
                cnt_n   = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    annul_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
